// File: rtl/pe_seq_ctrl.sv
// Sequencer for a weight-stationary MAC processing element: loads weights, streams
// activation vectors, and returns per-vector dot products as differences from a running base.
module pe_seq_ctrl #(
    parameter int IN_PRECISION  = 16,
    parameter int OUT_PRECISION = 32,
    parameter int REG_SIZE      = 4,
    parameter int LEN_W         = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(REG_SIZE)-1:0] num_wgt,
    input  logic [LEN_W-1:0]           num_vec,
    output logic                       busy,
    output logic                       cfg_err,
    input  logic                       wgt_valid,
    output logic                       wgt_ready,
    input  logic [IN_PRECISION-1:0]    wgt_data,
    input  logic                       act_valid,
    output logic                       act_ready,
    input  logic [IN_PRECISION-1:0]    act_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUT_PRECISION-1:0]   res_data,
    output logic                       pe_rst,
    output logic [IN_PRECISION-1:0]    pe_act,
    output logic [IN_PRECISION-1:0]    pe_wgt,
    output logic                       pe_store,
    output logic                       pe_reuse,
    output logic                       pe_finish,
    output logic [REG_SIZE-1:0]        pe_addr,
    input  logic [OUT_PRECISION-1:0]   pe_out
);

    localparam int IDX_W = $clog2(REG_SIZE);
    localparam logic [IDX_W:0] MAX_WGT = (IDX_W+1)'(REG_SIZE - 1);

    localparam logic [2:0] S_PRST    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;
    localparam logic [2:0] S_CAP     = 3'd5;
    localparam logic [2:0] S_OUT     = 3'd6;

    logic [2:0]               state;
    logic [2:0]               next_state;
    logic                     prst_cnt;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         nw_q;
    logic [LEN_W-1:0]         vec_cnt;
    logic [OUT_PRECISION-1:0] base;
    logic                     cfg_ok;
    logic                     wgt_fire;
    logic                     act_fire;
    logic                     last_idx;

    assign cfg_ok    = (num_wgt != '0) && ({1'b0, num_wgt} <= MAX_WGT);
    assign wgt_ready = (state == S_LOAD);
    assign act_ready = (state == S_COMPUTE);
    assign wgt_fire  = wgt_valid && wgt_ready;
    assign act_fire  = act_valid && act_ready;
    assign last_idx  = (idx == nw_q - 1'b1);

    // PE operands are zero unless a handshake is happening this very cycle,
    // so stalled COMPUTE cycles become harmless zero MACs.
    assign pe_store  = wgt_fire;
    assign pe_reuse  = act_fire;
    assign pe_finish = (state == S_FIN);
    assign pe_wgt    = wgt_fire ? wgt_data : '0;
    assign pe_act    = act_fire ? act_data : '0;
    assign pe_addr   = (wgt_fire || act_fire) ? REG_SIZE'(idx) + REG_SIZE'(1) : '0;

    always_comb begin
        next_state = state;
        case (state)
            S_PRST:    if (prst_cnt) next_state = S_IDLE;
            S_IDLE:    if (start && cfg_ok) next_state = S_LOAD;
            S_LOAD:    if (wgt_fire && last_idx)
                           next_state = (vec_cnt != '0) ? S_COMPUTE : S_IDLE;
            S_COMPUTE: if (act_fire && last_idx) next_state = S_FIN;
            S_FIN:     next_state = S_CAP;
            S_CAP:     next_state = S_OUT;
            S_OUT:     if (res_ready)
                           next_state = (vec_cnt == LEN_W'(1)) ? S_IDLE : S_COMPUTE;
            default:   next_state = S_PRST;
        endcase
    end

    // The PE accumulator is never cleared by start, so base survives commands
    // and is only zeroed together with a PE reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_PRST;
            prst_cnt  <= 1'b0;
            idx       <= '0;
            nw_q      <= '0;
            vec_cnt   <= '0;
            base      <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b1;
            cfg_err   <= 1'b0;
            pe_rst    <= 1'b1;
        end else begin
            state   <= next_state;
            busy    <= (next_state != S_IDLE);
            pe_rst  <= (next_state == S_PRST);
            cfg_err <= (state == S_IDLE) && start && !cfg_ok;
            case (state)
                S_PRST: begin
                    prst_cnt  <= !prst_cnt;
                    idx       <= '0;
                    vec_cnt   <= '0;
                    base      <= '0;
                    res_data  <= '0;
                    res_valid <= 1'b0;
                end
                S_IDLE: begin
                    if (start && cfg_ok) begin
                        nw_q    <= num_wgt;
                        vec_cnt <= num_vec;
                        idx     <= '0;
                    end
                end
                S_LOAD, S_COMPUTE: begin
                    if (wgt_fire || act_fire)
                        idx <= last_idx ? '0 : idx + 1'b1;
                end
                S_CAP: begin
                    res_data  <= pe_out - base;
                    base      <= pe_out;
                    res_valid <= 1'b1;
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        vec_cnt   <= vec_cnt - 1'b1;
                        idx       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
